// File: rtl/mem_pkg.sv
//------------------------------------------------------------------------------
// Module      : mem_pkg
// Description : Shared DRAM-path constants, buffer state encoding and
//               word select/merge helpers for 128-bit lines.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

    localparam int ADDR_W = 27;
    localparam int WORD_W = 32;
    localparam int LINE_W = 128;
    localparam int WORDS  = LINE_W / WORD_W;
    localparam int IDX_W  = $clog2(WORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HIT   = 3'd1,
        WB    = 3'd2,
        FILL  = 3'd3,
        FWAIT = 3'd4,
        DONE  = 3'd5
    } wlb_state_t;

    function automatic logic [WORD_W-1:0] word_sel(
        input logic [LINE_W-1:0] line,
        input logic [IDX_W-1:0]  idx
    );
        return line[idx*WORD_W +: WORD_W];
    endfunction

    function automatic logic [LINE_W-1:0] word_merge(
        input logic [LINE_W-1:0] line,
        input logic [IDX_W-1:0]  idx,
        input logic [WORD_W-1:0] data
    );
        logic [LINE_W-1:0] merged;
        merged = line;
        merged[idx*WORD_W +: WORD_W] = data;
        return merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/word_line_buffer.sv
//------------------------------------------------------------------------------
// Module      : word_line_buffer
// Description : Single-line write-back buffer turning 32-bit CPU word
//               accesses into 128-bit DRAM line reads and write-backs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module word_line_buffer #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int WORD_W = mem_pkg::WORD_W,
    parameter int LINE_W = mem_pkg::LINE_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wr,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [LINE_W-1:0] mem_rsp_rdata
);

    import mem_pkg::word_sel;
    import mem_pkg::word_merge;

    localparam int TAG_W = ADDR_W - 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HIT   = 3'd1;
    localparam logic [2:0] S_WB    = 3'd2;
    localparam logic [2:0] S_FILL  = 3'd3;
    localparam logic [2:0] S_FWAIT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]        r_state;
    logic [LINE_W-1:0] r_line;
    logic [TAG_W-1:0]  r_tag;
    logic              r_line_valid;
    logic              r_line_dirty;

    logic              r_req_wr;
    logic [TAG_W-1:0]  r_req_tag;
    logic [1:0]        r_req_idx;
    logic [WORD_W-1:0] r_req_wdata;

    logic              r_cpu_ready;
    logic              r_cpu_done;
    logic [WORD_W-1:0] r_cpu_rdata;
    logic              r_mem_req_valid;
    logic              r_mem_req_wr;
    logic [ADDR_W-1:0] r_mem_req_addr;
    logic [LINE_W-1:0] r_mem_req_wdata;

    logic              w_hit;
    logic [LINE_W-1:0] w_fill_line;
    logic              w_unused_addr_lsb;

    assign w_hit             = r_line_valid && (cpu_addr[ADDR_W-1:4] == r_tag);
    assign w_unused_addr_lsb = ^cpu_addr[1:0];

    // A store that misses gets its word merged into the arriving line.
    assign w_fill_line = r_req_wr ? word_merge(mem_rsp_rdata, r_req_idx, r_req_wdata)
                                  : mem_rsp_rdata;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state         <= S_IDLE;
            r_line          <= '0;
            r_tag           <= '0;
            r_line_valid    <= 1'b0;
            r_line_dirty    <= 1'b0;
            r_req_wr        <= 1'b0;
            r_req_tag       <= '0;
            r_req_idx       <= '0;
            r_req_wdata     <= '0;
            r_cpu_ready     <= 1'b1;
            r_cpu_done      <= 1'b0;
            r_cpu_rdata     <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_wr    <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_req_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_valid) begin
                        r_req_wr    <= cpu_wr;
                        r_req_tag   <= cpu_addr[ADDR_W-1:4];
                        r_req_idx   <= cpu_addr[3:2];
                        r_req_wdata <= cpu_wdata;
                        r_cpu_ready <= 1'b0;
                        if (w_hit) begin
                            r_state <= S_HIT;
                        end else if (r_line_valid && r_line_dirty) begin
                            r_mem_req_valid <= 1'b1;
                            r_mem_req_wr    <= 1'b1;
                            r_mem_req_addr  <= {r_tag, 4'b0000};
                            r_mem_req_wdata <= r_line;
                            r_state         <= S_WB;
                        end else begin
                            r_mem_req_valid <= 1'b1;
                            r_mem_req_wr    <= 1'b0;
                            r_mem_req_addr  <= {cpu_addr[ADDR_W-1:4], 4'b0000};
                            r_state         <= S_FILL;
                        end
                    end
                end
                S_HIT: begin
                    if (r_req_wr) begin
                        r_line       <= word_merge(r_line, r_req_idx, r_req_wdata);
                        r_line_dirty <= 1'b1;
                        r_cpu_rdata  <= r_req_wdata;
                    end else begin
                        r_cpu_rdata  <= word_sel(r_line, r_req_idx);
                    end
                    r_cpu_done <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_WB: begin
                    // Fill request follows on the next cycle, never alongside.
                    if (mem_req_ready) begin
                        r_line_dirty   <= 1'b0;
                        r_mem_req_wr   <= 1'b0;
                        r_mem_req_addr <= {r_req_tag, 4'b0000};
                        r_state        <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= S_FWAIT;
                    end
                end
                S_FWAIT: begin
                    if (mem_rsp_valid) begin
                        r_line       <= w_fill_line;
                        r_tag        <= r_req_tag;
                        r_line_valid <= 1'b1;
                        r_line_dirty <= r_req_wr;
                        r_state      <= S_HIT;
                    end
                end
                S_DONE: begin
                    r_cpu_done  <= 1'b0;
                    r_cpu_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_cpu_done      <= 1'b0;
                    r_cpu_ready     <= 1'b1;
                    r_mem_req_valid <= 1'b0;
                    r_state         <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_ready     = r_cpu_ready;
    assign cpu_done      = r_cpu_done;
    assign cpu_rdata     = r_cpu_rdata;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_wr    = r_mem_req_wr;
    assign mem_req_addr  = r_mem_req_addr;
    assign mem_req_wdata = r_mem_req_wdata;

endmodule

`default_nettype wire

// File: doc/word_line_buffer.md
# word_line_buffer

Single-line write-back buffer between the CPU-side word port and the DRAM request FIFO. It converts 32-bit word loads and stores into 128-bit line reads and writes toward the DRAM controller. Repeated accesses to the same 16-byte line are served locally without a DRAM round trip. It sits directly upstream of the DRAM request/response FIFO and is clocked by the CPU clock domain.

## Interface
Parameters:
- ADDR_W, 27, byte address width (matches DRAM request address)
- WORD_W, 32, CPU data width
- LINE_W, 128, DRAM line width; WORDS = LINE_W/WORD_W = 4

Ports:
- clk  in  1  CPU clock. Single clock, used for all logic.
- rstn  in  1  synchronous, active-low reset, sampled on rising clk
- cpu_valid  in  1  CPU request present
- cpu_ready  out  1  block can accept a request this cycle
- cpu_wr  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored (word-aligned)
- cpu_wdata  in  WORD_W  store data
- cpu_rdata  out  WORD_W  load data, valid while cpu_done=1
- cpu_done  out  1  one-cycle pulse: access complete
- mem_req_valid  out  1  DRAM request present
- mem_req_ready  in  1  FIFO accepts request
- mem_req_wr  out  1  1 = line write, 0 = line read
- mem_req_addr  out  ADDR_W  line address, bits [3:0] always 0
- mem_req_wdata  out  LINE_W  write-back line data
- mem_rsp_valid  in  1  read response present (single cycle, always accepted)
- mem_rsp_rdata  in  LINE_W  read response line

## Operation
- State held: one line register, line tag (cpu_addr[ADDR_W-1:4]), line_valid, and line_dirty.
- Word index is cpu_addr[3:2]; word i occupies bits [32*i+31 : 32*i] of the line.
- States and transitions:
  - IDLE: cpu_ready=1. On cpu_valid, latch wr/addr/wdata.
    - Hit (tag match and line_valid) -> HIT.
    - Miss with line_valid and line_dirty -> WB.
    - Otherwise -> FILL.
  - HIT: a load returns the selected word; a store merges the word and sets line_dirty. -> DONE.
  - WB: mem_req_valid=1, mem_req_wr=1, addr = {old tag, 4'b0}, wdata = line. On mem_req_ready, clear line_dirty -> FILL. Writes get no response.
  - FILL: mem_req_valid=1, mem_req_wr=0, addr = {new tag, 4'b0}. On mem_req_ready -> FWAIT.
  - FWAIT: on mem_rsp_valid, load the line, set tag, line_valid=1, line_dirty=0. If the request is a store, merge the word in the same cycle and set line_dirty=1. -> HIT-equivalent completion -> DONE.
  - DONE: cpu_done=1, cpu_rdata = selected word of the updated line. -> IDLE.
- mem_req_* stay stable while mem_req_valid=1 and mem_req_ready=0.
- mem_rsp_valid outside FWAIT is ignored and does not change state or data.
- cpu_valid while cpu_ready=0 is ignored; the CPU must hold its request until it sees cpu_ready.

## Timing
- Reset values: state=IDLE, cpu_ready=1, cpu_done=0, cpu_rdata=0, mem_req_valid=0, mem_req_wr=0, mem_req_addr=0, mem_req_wdata=0, line_valid=0, line_dirty=0.
- Hit latency: request accepted at cycle 0; cpu_done at cycle 2 (IDLE→HIT→DONE); next request can be accepted at cycle 3.
- Clean miss: cpu_done 2 cycles after mem_rsp_valid.
- Dirty miss: the write-back handshake precedes the fill request; the two requests are never issued in the same cycle.
- Reset mid-operation (any state): return to IDLE with the line invalidated, and without write-back; dirty data is lost. A late mem_rsp_valid arriving after reset is ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package mem_pkg: ADDR_W, WORD_W, LINE_W and WORDS constants; the state enum wlb_state_t {IDLE, HIT, WB, FILL, FWAIT, DONE}; and functions word_sel(line, idx) and word_merge(line, idx, data), which are reused by the DRAM side.
- No sub-module; a single always_ff FSM plus the line register.

## Test plan
- Cold load of 0x0000_040: FILL with mem_req_addr=0x40; respond with 0x33333333_22222222_11111111_00000000 -> cpu_rdata=0x00000000, cpu_done 2 cycles after the response.
- Load of 0x48 after the above -> no mem_req_valid, cpu_rdata=0x22222222, cpu_done exactly 2 cycles after acceptance.
- Store of 0xDEADBEEF to 0x44, then load of 0x1000 -> WB with addr=0x40, wdata=0x33333333_22222222_DEADBEEF_00000000, then FILL with addr=0x1000.
- Hold mem_req_ready=0 for 5 cycles during FILL -> mem_req_valid/addr stable, cpu_ready=0, no cpu_done.
- Assert rstn=0 for 1 cycle in FWAIT, then pulse mem_rsp_valid -> state IDLE, line_valid=0, response ignored; a following load of the same address misses.
- mem_rsp_valid asserted in IDLE with a random line -> no output change; a subsequent hit returns the previous data.
